// File: rtl/mix_col_seq.sv
// mix_col_seq: streams a 128-bit AES state through one 32-bit MixColumns unit, one column per cycle; out_valid 4 cycles after accept.
// Result is held in DONE until out_ready, and no input is accepted meanwhile; `MIX_COL_INV_EN enables the in_inv/InvMixColumns path.
module mix_col_seq #(
   parameter int COLS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy,
   output logic [31:0]  mc_col_o,
   output logic         mc_inv_en,
   input  logic [31:0]  mc_col_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [1:0] LAST_COL = 2'(COLS - 1);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [127:0] r_buf;
   logic [1:0]   r_col_cnt;
   logic         w_inv_q;
   logic [31:0]  w_col_rd;
   logic         w_accept;

   assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef MIX_COL_INV_EN
   logic r_inv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inv_q <= 1'b0;
      end else if (w_accept) begin
         r_inv_q <= in_inv;
      end
   end

   assign w_inv_q = r_inv_q;
`else
   logic w_unused_inv;

   assign w_unused_inv = in_inv;
   assign w_inv_q      = 1'b0;
`endif

   // Column 0 is the most significant word of the state.
   always_comb begin
      w_col_rd = r_buf[127:96];
      unique case (r_col_cnt)
         2'd0: w_col_rd = r_buf[127:96];
         2'd1: w_col_rd = r_buf[95:64];
         2'd2: w_col_rd = r_buf[63:32];
         2'd3: w_col_rd = r_buf[31:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_state   = '0;
      busy        = 1'b0;
      mc_col_o    = '0;
      mc_inv_en   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy      = 1'b1;
            mc_col_o  = w_col_rd;
            mc_inv_en = w_inv_q;
            if (r_col_cnt == LAST_COL) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_state = r_buf;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The datapath result is written back in place over the column it came from.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf     <= '0;
         r_col_cnt <= '0;
      end else if (w_accept) begin
         r_buf     <= in_state;
         r_col_cnt <= '0;
      end else if (r_state == S_RUN) begin
         unique case (r_col_cnt)
            2'd0: r_buf[127:96] <= mc_col_i;
            2'd1: r_buf[95:64]  <= mc_col_i;
            2'd2: r_buf[63:32]  <= mc_col_i;
            2'd3: r_buf[31:0]   <= mc_col_i;
         endcase
         r_col_cnt <= r_col_cnt + 2'd1;
      end
   end

endmodule

// File: tb/tb_mix_col_seq.sv
// Bench for mix_col_seq: a behavioural GF(2^8) MixColumns model drives the mc_* ports and predicts every output state.
module tb_mix_col_seq;

`ifdef MIX_COL_INV_EN
   localparam bit INV_BUILT = 1'b1;
`else
   localparam bit INV_BUILT = 1'b0;
`endif

   localparam logic [127:0] S1   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] EXP1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] S3   = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
   localparam logic [127:0] EXP3 = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_inv;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;
   logic [31:0]  mc_col_o;
   logic         mc_inv_en;
   logic [31:0]  mc_col_i;

   int n_tests = 0;
   int n_fail  = 0;

   mix_col_seq #(.COLS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy),
      .mc_col_o  (mc_col_o),
      .mc_inv_en (mc_inv_en),
      .mc_col_i  (mc_col_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] mix_col_ref(input logic [31:0] col, input logic inv);
      logic [7:0]  a [4];
      logic [7:0]  k [4];
      logic [7:0]  acc;
      logic [31:0] r;
      for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
      if (inv) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     k = '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int i = 0; i < 4; i++) begin
         acc = 8'h00;
         for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[(j - i) & 3], a[j]);
         r[31-8*i -: 8] = acc;
      end
      return r;
   endfunction

   function automatic logic [127:0] state_ref(input logic [127:0] s, input logic inv);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col_ref(s[127-32*c -: 32], inv);
      return r;
   endfunction

   assign mc_col_i = mix_col_ref(mc_col_o, mc_inv_en);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a state and returns just after the accepting edge (E0).
   task automatic accept(input logic [127:0] s, input logic inv);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_state = s;
      in_inv   = inv;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_state  = '0;
      in_inv    = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({in_ready, out_valid, busy, mc_inv_en, mc_col_o, out_state} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0}) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b inv=%b col=%h st=%h, required 1 0 0 0 0 0",
                  in_ready, out_valid, busy, mc_inv_en, mc_col_o, out_state);
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL post_reset_idle: rdy/vld/busy=%b, required 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_forward();
      out_ready = 1'b1;
      accept(S1, 1'b0);
      for (int c = 0; c < 4; c++) begin
         n_tests++;
         if (mc_col_o !== S1[127-32*c -: 32] || mc_inv_en !== 1'b0 || busy !== 1'b1 ||
             in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_run_col%0d: col=%h inv=%b busy=%b rdy=%b vld=%b, required col=%h inv=0 busy=1 rdy=0 vld=0",
                     c, mc_col_o, mc_inv_en, busy, in_ready, out_valid, S1[127-32*c -: 32]);
         end
         tick();
      end
      n_tests++;
      if (out_valid !== 1'b1 || out_state !== EXP1) begin
         n_fail++;
         $display("FAIL fwd_result: vld=%b state=%h, required 1 %h", out_valid, out_state, EXP1);
      end
      tick();
      n_tests++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL fwd_back_idle: rdy/vld/busy=%b, required 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      accept(S1, 1'b0);
      repeat (4) tick();
      for (int k = 0; k < 10; k++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_state !== EXP1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: vld=%b rdy=%b busy=%b state=%h, required vld=1 rdy=0 busy=1 %h",
                     k, out_valid, in_ready, busy, out_state, EXP1);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      n_tests++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL bp_release: rdy/vld/busy=%b, required 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_inverse();
      logic [127:0] exp;
      exp       = INV_BUILT ? EXP3 : state_ref(S3, 1'b0);
      out_ready = 1'b1;
      n_tests++;
      if (mc_inv_en !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_en_idle: mc_inv_en=%b, required 0", mc_inv_en);
      end
      accept(S3, 1'b1);
      for (int c = 0; c < 4; c++) begin
         n_tests++;
         if (mc_inv_en !== INV_BUILT) begin
            n_fail++;
            $display("FAIL inv_en_run%0d: mc_inv_en=%b, required %b", c, mc_inv_en, INV_BUILT);
         end
         tick();
      end
      n_tests++;
      if (out_valid !== 1'b1 || out_state !== exp || mc_inv_en !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_result: vld=%b inv_en=%b state=%h, required 1 0 %h", out_valid, mc_inv_en, out_state, exp);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [127:0] a;
      logic [127:0] b;
      logic         ia;
      logic         ib;
      int           acc_at[$];
      logic [127:0] outs[$];
      a         = {$urandom(), $urandom(), $urandom(), $urandom()};
      b         = {$urandom(), $urandom(), $urandom(), $urandom()};
      ia        = 1'($urandom_range(0, 1));
      ib        = 1'($urandom_range(0, 1));
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = a;
      in_inv    = ia;
      for (int k = 0; k < 13; k++) begin
         if (in_ready && in_valid) acc_at.push_back(k);
         if (out_valid) outs.push_back(out_state);
         if (k >= 1 && k <= 11) begin
            n_tests++;
            if (busy !== (k != 6)) begin
               n_fail++;
               $display("FAIL b2b_busy_step%0d: busy=%b, required %b", k, busy, (k != 6));
            end
         end
         tick();
         if (acc_at.size() == 1) begin
            in_state = b;
            in_inv   = ib;
         end else if (acc_at.size() == 2) begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_tests++;
      if (acc_at.size() != 2 || acc_at[1] - acc_at[0] != 6) begin
         n_fail++;
         $display("FAIL b2b_accept_spacing: accepts=%0d spacing=%0d, required 2 and 6",
                  acc_at.size(), (acc_at.size() == 2) ? acc_at[1] - acc_at[0] : -1);
      end
      n_tests++;
      if (outs.size() != 2 || outs[0] !== state_ref(a, ia & INV_BUILT) || outs[1] !== state_ref(b, ib & INV_BUILT)) begin
         n_fail++;
         $display("FAIL b2b_results: count=%0d, required 2 in order %h then %h",
                  outs.size(), state_ref(a, ia & INV_BUILT), state_ref(b, ib & INV_BUILT));
      end
   endtask

   task automatic test_reset_mid_run();
      int seen_vld;
      out_ready = 1'b1;
      accept(S1, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({in_ready, out_valid, busy, mc_inv_en, mc_col_o, out_state} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0}) begin
         n_fail++;
         $display("FAIL midrun_reset_outputs: rdy=%b vld=%b busy=%b inv=%b col=%h st=%h, required 1 0 0 0 0 0",
                  in_ready, out_valid, busy, mc_inv_en, mc_col_o, out_state);
      end
      tick();
      rst_n    = 1'b1;
      seen_vld = 0;
      for (int k = 0; k < 6; k++) begin
         if (out_valid || busy) seen_vld++;
         tick();
      end
      n_tests++;
      if (seen_vld != 0) begin
         n_fail++;
         $display("FAIL midrun_no_output: busy/out_valid seen %0d cycles, required 0", seen_vld);
      end
      accept(S1, 1'b0);
      repeat (4) tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_state !== EXP1) begin
         n_fail++;
         $display("FAIL midrun_fresh_txn: vld=%b state=%h, required 1 %h", out_valid, out_state, EXP1);
      end
      tick();
   endtask

   task automatic test_input_stability();
      logic [127:0] s;
      logic [127:0] exp;
      logic         inv;
      out_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         s   = {$urandom(), $urandom(), $urandom(), $urandom()};
         inv = 1'($urandom_range(0, 1));
         exp = state_ref(s, inv & INV_BUILT);
         accept(s, inv);
         for (int c = 0; c < 4; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_inv   = 1'($urandom_range(0, 1));
            tick();
         end
         in_valid = 1'b0;
         n_tests++;
         if (out_valid !== 1'b1 || out_state !== exp) begin
            n_fail++;
            $display("FAIL stability_%0d: vld=%b state=%h, required 1 %h", t, out_valid, out_state, exp);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [127:0] s;
      logic [127:0] exp;
      logic         inv;
      int           stall;
      for (int t = 0; t < 20; t++) begin
         s         = {$urandom(), $urandom(), $urandom(), $urandom()};
         inv       = 1'($urandom_range(0, 1));
         stall     = $urandom_range(0, 3);
         exp       = state_ref(s, inv & INV_BUILT);
         out_ready = 1'b0;
         accept(s, inv);
         repeat (4) tick();
         for (int k = 0; k <= stall; k++) begin
            if (k == stall) out_ready = 1'b1;
            n_tests++;
            if (out_valid !== 1'b1 || out_state !== exp) begin
               n_fail++;
               $display("FAIL random_%0d_wait%0d: vld=%b state=%h, required 1 %h", t, k, out_valid, out_state, exp);
            end
            tick();
         end
         n_tests++;
         if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL random_%0d_idle: rdy/vld=%b, required 10", t, {in_ready, out_valid});
         end
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_backpressure();
      test_inverse();
      test_back_to_back();
      test_reset_mid_run();
      test_input_stability();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
